arb_chan_fifo: RTL

//  Per-channel input buffer placed directly upstream of one rrp_arbiter port.

---
 rtl/arb_chan_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/arb_chan_fifo.sv
// Per-channel first-word-fall-through buffer feeding one rrp_arbiter port.
// It holds source words, presents the head word with WRITE_REQ, raises HOLD_REQ
// above a fill threshold, pops on READ_GRANT and counts writes dropped while full.
module arb_chan_fifo #(
  parameter int unsigned ADDR_SIZE      = 4,
  parameter int unsigned HOLD_THRESHOLD = 12
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_WRITE,
  input  logic [31:0]          IN_DATA,
  output logic                 IN_FULL,
  input  logic                 CLR_LOST,
  output logic [7:0]           LOST_COUNT,
  output logic [ADDR_SIZE:0]   FIFO_LEVEL,
  output logic                 WRITE_REQ,
  output logic                 HOLD_REQ,
  output logic [31:0]          DATA_OUT,
  input  logic                 READ_GRANT
);

  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDR_SIZE;
  localparam int unsigned CW    = 8;

  logic [DW-1:0]        mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [LW-1:0]        level_next;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // A write while full is dropped even if a pop frees a slot this same cycle.
  assign push = IN_WRITE & ~IN_FULL;
  assign drop = IN_WRITE & IN_FULL;
  assign pop  = READ_GRANT & WRITE_REQ;

  // Next fill level; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_next = FIFO_LEVEL;
    if (push && !pop) begin
      level_next = FIFO_LEVEL + LW'(1);
    end else if (pop && !push) begin
      level_next = FIFO_LEVEL - LW'(1);
    end
  end

  // Storage array; not reset so contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= IN_DATA;
    end
  end

  // Pointers, level and flags, all flags derived from the next level.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
      IN_FULL    <= 1'b0;
      WRITE_REQ  <= 1'b0;
      HOLD_REQ   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      FIFO_LEVEL <= level_next;
      IN_FULL    <= (level_next == LW'(DEPTH));
      WRITE_REQ  <= (level_next != '0);
      HOLD_REQ   <= (32'(level_next) >= HOLD_THRESHOLD);
    end
  end

  // Saturating drop counter; a clear takes priority over a simultaneous drop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LOST_COUNT <= '0;
    end else if (CLR_LOST) begin
      LOST_COUNT <= '0;
    end else if (drop && (LOST_COUNT != {CW{1'b1}})) begin
      LOST_COUNT <= LOST_COUNT + CW'(1);
    end
  end

  // Head word: rd_ptr and the slot it addresses only change at the clock edge,
  // so this stays stable for the whole cycle the arbiter samples it.
  assign DATA_OUT = WRITE_REQ ? mem[rd_ptr] : '0;

endmodule
